// File: rtl/hb_pkg.sv
// rtl/hb_pkg.sv - shared types and constants for the heartbeat supervisor slice
//
// Purpose: FSM state encoding, default widths and FIX MsgType (tag 35) values
//          shared by the supervisor, the parser and the transmit path.
// Ports:   none (package).
package hb_pkg;

  localparam int HB_RANGE_DEF = 16;
  localparam int ID_W_DEF = 8;

  // FIX MsgType values as the ASCII byte that follows "35=".
  localparam logic [7:0] MSG_HEARTBEAT    = 8'h30;  // '0'
  localparam logic [7:0] MSG_TEST_REQUEST = 8'h31;  // '1'
  localparam logic [7:0] MSG_LOGOUT       = 8'h35;  // '5'

  typedef enum logic [2:0] {
    IDLE,
    SEND_TR,
    WAIT_RESP,
    LOGOUT,
    DEAD
  } state_t;

endpackage

// File: rtl/hb_grace_timer.sv
// rtl/hb_grace_timer.sv - grace-period counter with compare against a latched window
//
// Purpose: counts cycles after a TestRequest is accepted and flags the cycle
//          on which the count reaches the latched grace value.
// Ports:   clk     - clock, rising edge
//          rst     - synchronous active-low reset
//          load    - clear the count and latch grace
//          grace   - response window in cycles (0 = single-cycle window)
//          expired - high while count equals the latched window
module hb_grace_timer
  import hb_pkg::*;
#(
  parameter int HB_RANGE = HB_RANGE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [HB_RANGE-1:0] grace,
  output logic                expired
);

  logic [HB_RANGE-1:0] count;
  logic [HB_RANGE-1:0] grace_q;

  assign expired = (count == grace_q);

  // The count holds once it reaches the window, so it can never wrap even if
  // the owner lingers in a state that does not reload it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count   <= '0;
      grace_q <= '0;
    end else if (load) begin
      count   <= '0;
      grace_q <= grace;
    end else if (!expired) begin
      count   <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hb_test_request_supervisor.sv
// rtl/hb_test_request_supervisor.sv - FIX TestRequest/Logout liveness supervisor
//
// Purpose: on a heartbeat-threshold pulse issue a TestRequest with a fresh
//          TestReqID, wait a grace window for the echoing Heartbeat, and
//          request Logout / mark the session dead if none arrives.
// Ports:   clk, rst (sync active-low)
//          threshold_reached_i           - pulse from the heartbeat counter
//          grace_cycles_i                - window, sampled when the request is acked
//          rx_heartbeat_i, rx_test_req_id_i - decoded Heartbeat and its TestReqID
//          test_req_ack_i                - transmit path accepts the TestRequest
//          session_restart_i             - leave DEAD
//          test_req_valid_o, test_req_id_o - pending TestRequest and its ID
//          logout_req_o                  - one-cycle Logout request
//          session_dead_o                - high while DEAD
// Config:  HB_TEST_REQUEST_SUPERVISOR_RETRY_EN adds MAX_RETRY reissues before Logout.
module hb_test_request_supervisor
  import hb_pkg::*;
#(
  parameter int HB_RANGE = HB_RANGE_DEF,
  parameter int ID_W     = ID_W_DEF
`ifdef HB_TEST_REQUEST_SUPERVISOR_RETRY_EN
  ,
  parameter int MAX_RETRY = 1
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                threshold_reached_i,
  input  logic [HB_RANGE-1:0] grace_cycles_i,
  input  logic                rx_heartbeat_i,
  input  logic [ID_W-1:0]     rx_test_req_id_i,
  input  logic                test_req_ack_i,
  input  logic                session_restart_i,
  output logic                test_req_valid_o,
  output logic [ID_W-1:0]     test_req_id_o,
  output logic                logout_req_o,
  output logic                session_dead_o
);

  state_t state;
  logic   timer_load;
  logic   expired;
  logic   match;

  assign timer_load = (state == SEND_TR) && test_req_ack_i;
  assign match      = rx_heartbeat_i && (rx_test_req_id_i == test_req_id_o);

  hb_grace_timer #(
    .HB_RANGE(HB_RANGE)
  ) u_grace_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .grace  (grace_cycles_i),
    .expired(expired)
  );

`ifdef HB_TEST_REQUEST_SUPERVISOR_RETRY_EN
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retries;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      test_req_valid_o <= 1'b0;
      test_req_id_o    <= '0;
      logout_req_o     <= 1'b0;
      session_dead_o   <= 1'b0;
`ifdef HB_TEST_REQUEST_SUPERVISOR_RETRY_EN
      retries          <= '0;
`endif
    end else begin
      logout_req_o <= 1'b0;
      case (state)
        IDLE: begin
`ifdef HB_TEST_REQUEST_SUPERVISOR_RETRY_EN
          retries <= '0;
`endif
          if (threshold_reached_i) begin
            test_req_id_o    <= test_req_id_o + 1'b1;
            test_req_valid_o <= 1'b1;
            state            <= SEND_TR;
          end
        end
        // Heartbeats here are ignored: the request is not on the wire yet.
        SEND_TR: begin
          if (test_req_ack_i) begin
            test_req_valid_o <= 1'b0;
            state            <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (match) begin
`ifdef HB_TEST_REQUEST_SUPERVISOR_RETRY_EN
            retries <= '0;
`endif
            state <= IDLE;
          end else if (expired) begin
`ifdef HB_TEST_REQUEST_SUPERVISOR_RETRY_EN
            if (retries < RW'(MAX_RETRY)) begin
              // Reissue with a new ID so a late echo of the old one cannot match.
              retries          <= retries + 1'b1;
              test_req_id_o    <= test_req_id_o + 1'b1;
              test_req_valid_o <= 1'b1;
              state            <= SEND_TR;
            end else begin
              logout_req_o <= 1'b1;
              state        <= LOGOUT;
            end
`else
            logout_req_o <= 1'b1;
            state        <= LOGOUT;
`endif
          end
        end
        LOGOUT: begin
          session_dead_o <= 1'b1;
          state          <= DEAD;
        end
        DEAD: begin
          if (session_restart_i) begin
            session_dead_o <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          test_req_valid_o <= 1'b0;
          session_dead_o   <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule
